// File: rtl/mix_column_engine.sv
// Sequential AES/Rijndael MixColumns / InvMixColumns engine. Accepts a full state,
// transforms COLS_PER_CYCLE columns per beat and presents the result until taken.
module mix_column_engine #(
    parameter int NUM_COLS       = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_inverse,
    input  logic [3:0][NUM_COLS-1:0][7:0]    in_state,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [3:0][NUM_COLS-1:0][7:0]    out_state,
    output logic                             busy
);

    localparam int BEATS  = NUM_COLS / COLS_PER_CYCLE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (COLS_PER_CYCLE < 1 || !(NUM_COLS == 4 || NUM_COLS == 6 || NUM_COLS == 8) ||
        (NUM_COLS % COLS_PER_CYCLE) != 0) begin : g_bad_params
        $error("mix_column_engine: illegal NUM_COLS=%0d / COLS_PER_CYCLE=%0d",
               NUM_COLS, COLS_PER_CYCLE);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, reduction polynomial 0x11B, built from xtime only.
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    // One output byte: a0 is the byte in the same row, a1..a3 the following rows mod 4.
    function automatic logic [7:0] mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3,
                                            input logic inv);
        if (inv) begin
            return mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        end
        return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    endfunction

    function automatic logic [3:0][7:0] mix_column(input logic [3:0][7:0] a, input logic inv);
        logic [3:0][7:0] b;
        b[0] = mix_byte(a[0], a[1], a[2], a[3], inv);
        b[1] = mix_byte(a[1], a[2], a[3], a[0], inv);
        b[2] = mix_byte(a[2], a[3], a[0], a[1], inv);
        b[3] = mix_byte(a[3], a[0], a[1], a[2], inv);
        return b;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                          state;
    state_t                          state_next;
    logic [BEAT_W-1:0]               beat;
    logic                            mode;
    logic [3:0][NUM_COLS-1:0][7:0]   work;
    logic [3:0][NUM_COLS-1:0][7:0]   work_next;
    logic [3:0][COLS_PER_CYCLE-1:0][7:0] mixed;

    // The lanes always read the lowest COLS_PER_CYCLE columns; the register rotates
    // by one group per beat, so after BEATS beats every column is back in place.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        logic [3:0][7:0] col_in;
        logic [3:0][7:0] col_out;

        assign col_in  = {work[3][k], work[2][k], work[1][k], work[0][k]};
        assign col_out = mix_column(col_in, mode);

        for (genvar r = 0; r < 4; r++) begin : g_row
            assign mixed[r][k] = col_out[r];
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_rotate
        if (COLS_PER_CYCLE == NUM_COLS) begin : g_single
            assign work_next[r] = mixed[r];
        end else begin : g_multi
            assign work_next[r] = {mixed[r], work[r][NUM_COLS-1:COLS_PER_CYCLE]};
        end
    end

    // NOTE: the working register is reset along with the FSM so a discarded block
    // can never leak onto out_state; it is a flop bank, not a RAM, so this is cheap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            mode  <= 1'b0;
            work  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_state;
                        mode <= in_inverse;
                        beat <= '0;
                    end
                end
                BUSY: begin
                    work <= work_next;
                    beat <= beat + BEAT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: state_next takes its hold value before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)          state_next = BUSY;
            BUSY:    if (beat == LAST_BEAT) state_next = DONE;
            DONE:    if (out_ready)         state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on this cycle's inputs.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_state = work;

endmodule
